gpr_mp: RTL and testbench

- Parametrised multi-port general-purpose register file for the pipelined MIPS core.
- Generalises the single-write register file with the following features:
  - NRD read ports.
  - Two prioritised write ports.
  - Write-to-read bypass.
  - A per-register pending-write scoreboard that drives hazard flags to the issue stage.
- Sits between decode/issue (read, issue) and the writeback stage (writes).

---
 rtl/gpr_pkg.sv | 21 ++
 rtl/gpr_sb.sv | 79 +++++++
 rtl/gpr_mp.sv | 94 +++++++++
 tb/tb_gpr_mp.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// Shared constants and helpers for the multi-port register file and its scoreboard.
// Defines the default widths, the hardwired-zero register index and a flattened-port slice helper.
package gpr_pkg;

  localparam int unsigned REG_ZERO   = 0;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;

  // Per-register scoreboard action for one clock edge.
  typedef enum logic [1:0] {
    SB_HOLD  = 2'd0,
    SB_CLEAR = 2'd1,
    SB_SET   = 2'd2
  } sb_op_e;

  // Low bit index of lane idx inside a flattened bus of w-bit lanes.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/gpr_sb.sv
// Pending-write scoreboard: one busy bit per register plus a registered popcount.
// Priority per edge is flush, then issue-set, then writeback-clear.
module gpr_sb
  import gpr_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     clr0_en,
  input  logic [ADDR_W-1:0]        clr0_addr,
  input  logic                     clr1_en,
  input  logic [ADDR_W-1:0]        clr1_addr,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  output logic [(2**ADDR_W)-1:0]   busy,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_reg;

  // The zero register can never have a pending producer.
  assign busy_next[REG_ZERO] = 1'b0;

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_bit
      sb_op_e op;

      always_comb begin
        op = SB_HOLD;
        if (flush) begin
          op = SB_CLEAR;
        end else if (set_en && (set_addr == ADDR_W'(gi))) begin
          // A newly issued producer supersedes a retiring one.
          op = SB_SET;
        end else if ((clr1_en && (clr1_addr == ADDR_W'(gi))) ||
                     (clr0_en && (clr0_addr == ADDR_W'(gi)))) begin
          op = SB_CLEAR;
        end
      end

      always_comb begin
        case (op)
          SB_SET:   busy_next[gi] = 1'b1;
          SB_CLEAR: busy_next[gi] = 1'b0;
          default:  busy_next[gi] = busy_reg[gi];
        endcase
      end
    end
  endgenerate

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_next = cnt_next + CNT_W'(busy_next[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      busy_reg <= busy_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign busy     = busy_reg;
  assign busy_cnt = cnt_reg;

endmodule

// File: rtl/gpr_mp.sv
// Multi-port register file: NRD bypassed read ports, two prioritised write ports,
// and per-port hazard flags driven from the pending-write scoreboard.
module gpr_mp
  import gpr_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we0,
  input  logic [ADDR_W-1:0]       wa0,
  input  logic [DATA_W-1:0]       wd0,
  input  logic                    we1,
  input  logic [ADDR_W-1:0]       wa1,
  input  logic [DATA_W-1:0]       wd1,
  input  logic [NRD*ADDR_W-1:0]   ra,
  output logic [NRD*DATA_W-1:0]   rd,
  output logic [NRD-1:0]          rhaz,
  input  logic                    iss_en,
  input  logic [ADDR_W-1:0]       iss_addr,
  input  logic                    flush,
  output logic [ADDR_W:0]         busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic              eff0;
  logic              eff1;
  logic              iss_eff;
  logic [DEPTH-1:0]  busy;
  logic [DATA_W-1:0] regs [DEPTH];

  assign eff0    = we0 && (wa0 != ZERO_ADDR);
  assign eff1    = we1 && (wa1 != ZERO_ADDR);
  assign iss_eff = iss_en && (iss_addr != ZERO_ADDR);

  // Entry 0 is reset and then never written, so it stays zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (eff1 && (wa1 == ADDR_W'(i))) begin
          regs[i] <= wd1;
        end else if (eff0 && (wa0 == ADDR_W'(i))) begin
          regs[i] <= wd0;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              hit0;
      logic              hit1;

      assign addr = ra[slice_lo(gi, ADDR_W) +: ADDR_W];
      assign hit1 = eff1 && (wa1 == addr);
      assign hit0 = eff0 && (wa0 == addr);

      assign rd[slice_lo(gi, DATA_W) +: DATA_W] =
        (addr == ZERO_ADDR) ? '0  :
        hit1                ? wd1 :
        hit0                ? wd0 :
                              regs[addr];

      // A value retiring this cycle is forwarded above, so it is not a hazard.
      assign rhaz[gi] = (addr != ZERO_ADDR) && busy[addr] && !hit1 && !hit0;
    end
  endgenerate

  gpr_sb #(
    .ADDR_W(ADDR_W)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .clr0_en   (eff0),
    .clr0_addr (wa0),
    .clr1_en   (eff1),
    .clr1_addr (wa1),
    .set_en    (iss_eff),
    .set_addr  (iss_addr),
    .busy      (busy),
    .busy_cnt  (busy_cnt)
  );

endmodule

// File: tb/tb_gpr_mp.sv
// Directed self-checking bench for gpr_mp: reset, dual write, register zero,
// scoreboard set/clear/collision, flush and back-to-back traffic.
module tb_gpr_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          we0, we1;
  logic [AW-1:0] wa0, wa1;
  logic [DW-1:0] wd0, wd1;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] rd;
  logic [NR-1:0] rhaz;
  logic          iss_en;
  logic [AW-1:0] iss_addr;
  logic          flush;
  logic [AW:0]   busy_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpr_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) dut (
    .clk      (clk),
    .reset    (reset),
    .we0      (we0),
    .wa0      (wa0),
    .wd0      (wd0),
    .we1      (we1),
    .wa1      (wa1),
    .wd1      (wd1),
    .ra       (ra),
    .rd       (rd),
    .rhaz     (rhaz),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .busy_cnt (busy_cnt)
  );

  function automatic logic [DW-1:0] rdp(input int p);
    return rd[p*DW +: DW];
  endfunction

  task automatic set_ra(input int p, input logic [AW-1:0] a);
    ra[p*AW +: AW] = a;
  endtask

  task automatic idle();
    we0 = 0; wa0 = '0; wd0 = '0;
    we1 = 0; wa1 = '0; wd1 = '0;
    iss_en = 0; iss_addr = '0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    ra = '0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", busy_cnt); end
    checks++; if (rd !== 64'd0) begin errors++; $display("FAIL reset_rd got %h want 0", rd); end

    for (int n = 1; n < 32; n++) begin
      we0 = 1; wa0 = AW'(n); wd0 = 32'hA5A50000 + 32'(n);
      tick();
    end
    idle();
    set_ra(0, 5'd7); set_ra(1, 5'd31);
    #1;
    checks++; if (rdp(0) !== 32'hA5A50007) begin errors++; $display("FAIL fill_r7 got %h want a5a50007", rdp(0)); end
    checks++; if (rdp(1) !== 32'hA5A5001F) begin errors++; $display("FAIL fill_r31 got %h want a5a5001f", rdp(1)); end

    iss_en = 1; iss_addr = 5'd2;
    tick();
    idle();
    #1;
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL pre_reset_cnt got %0d want 1", busy_cnt); end

    we1 = 1; wa1 = 5'd12; wd1 = 32'h12345678;
    #3;
    reset = 1'b0;
    #1;
    checks++; if (rd !== 64'd0) begin errors++; $display("FAIL async_rd got %h want 0", rd); end
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL async_cnt got %0d want 0", busy_cnt); end
    checks++; if (rhaz !== 2'b00) begin errors++; $display("FAIL async_rhaz got %b want 00", rhaz); end
    idle();
    @(negedge clk);
    reset = 1'b1;
    tick();
    set_ra(0, 5'd12);
    #1;
    checks++; if (rdp(0) !== 32'd0) begin errors++; $display("FAIL lost_write got %h want 0", rdp(0)); end
    $display("test_reset done");
  endtask

  task automatic test_dual_write();
    we0 = 1; wa0 = 5'd7; wd0 = 32'h11111111;
    we1 = 1; wa1 = 5'd7; wd1 = 32'h22222222;
    set_ra(0, 5'd7); set_ra(1, 5'd7);
    #1;
    checks++; if (rdp(0) !== 32'h22222222) begin errors++; $display("FAIL dual_bypass got %h want 22222222", rdp(0)); end
    tick();
    idle();
    #1;
    checks++; if (rdp(1) !== 32'h22222222) begin errors++; $display("FAIL dual_store got %h want 22222222", rdp(1)); end

    we0 = 1; wa0 = 5'd10; wd0 = 32'h10101010;
    we1 = 1; wa1 = 5'd11; wd1 = 32'h0B0B0B0B;
    set_ra(0, 5'd10); set_ra(1, 5'd11);
    #1;
    checks++; if (rdp(0) !== 32'h10101010) begin errors++; $display("FAIL diff_bypass0 got %h want 10101010", rdp(0)); end
    checks++; if (rdp(1) !== 32'h0B0B0B0B) begin errors++; $display("FAIL diff_bypass1 got %h want 0b0b0b0b", rdp(1)); end
    tick();
    idle();
    #1;
    checks++; if (rdp(0) !== 32'h10101010) begin errors++; $display("FAIL diff_store0 got %h want 10101010", rdp(0)); end
    checks++; if (rdp(1) !== 32'h0B0B0B0B) begin errors++; $display("FAIL diff_store1 got %h want 0b0b0b0b", rdp(1)); end
    $display("test_dual_write done");
  endtask

  task automatic test_reg0();
    we0 = 1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
    we1 = 1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF;
    iss_en = 1; iss_addr = 5'd0;
    set_ra(0, 5'd0); set_ra(1, 5'd0);
    #1;
    checks++; if (rdp(0) !== 32'd0) begin errors++; $display("FAIL r0_bypass got %h want 0", rdp(0)); end
    checks++; if (rhaz !== 2'b00) begin errors++; $display("FAIL r0_rhaz got %b want 00", rhaz); end
    tick();
    idle();
    #1;
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL r0_cnt got %0d want 0", busy_cnt); end
    checks++; if (rdp(1) !== 32'd0) begin errors++; $display("FAIL r0_store got %h want 0", rdp(1)); end
    $display("test_reg0 done");
  endtask

  task automatic test_scoreboard();
    iss_en = 1; iss_addr = 5'd5;
    tick();
    idle();
    set_ra(0, 5'd5);
    #1;
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL sb_cnt_set got %0d want 1", busy_cnt); end
    checks++; if (rhaz[0] !== 1'b1) begin errors++; $display("FAIL sb_rhaz_set got %b want 1", rhaz[0]); end
    we0 = 1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
    #1;
    checks++; if (rhaz[0] !== 1'b0) begin errors++; $display("FAIL sb_rhaz_fwd got %b want 0", rhaz[0]); end
    checks++; if (rdp(0) !== 32'hDEADBEEF) begin errors++; $display("FAIL sb_rd_fwd got %h want deadbeef", rdp(0)); end
    tick();
    idle();
    #1;
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL sb_cnt_clr got %0d want 0", busy_cnt); end
    checks++; if (rhaz[0] !== 1'b0) begin errors++; $display("FAIL sb_rhaz_clr got %b want 0", rhaz[0]); end
    $display("test_scoreboard done");
  endtask

  task automatic test_collision();
    iss_en = 1; iss_addr = 5'd9;
    tick();
    idle();
    set_ra(1, 5'd9);
    #1;
    checks++; if (rhaz[1] !== 1'b1) begin errors++; $display("FAIL col_pre_rhaz got %b want 1", rhaz[1]); end
    we1 = 1; wa1 = 5'd9; wd1 = 32'h09090909;
    iss_en = 1; iss_addr = 5'd9;
    #1;
    checks++; if (rhaz[1] !== 1'b0) begin errors++; $display("FAIL col_fwd_rhaz got %b want 0", rhaz[1]); end
    tick();
    idle();
    #1;
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL col_cnt got %0d want 1", busy_cnt); end
    checks++; if (rhaz[1] !== 1'b1) begin errors++; $display("FAIL col_rhaz got %b want 1", rhaz[1]); end
    checks++; if (rdp(1) !== 32'h09090909) begin errors++; $display("FAIL col_rd got %h want 09090909", rdp(1)); end
    we1 = 1; wa1 = 5'd9; wd1 = 32'h09090909;
    tick();
    idle();
    #1;
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL col_clr_cnt got %0d want 0", busy_cnt); end
    $display("test_collision done");
  endtask

  task automatic test_flush();
    int addrs[4] = '{3, 4, 6, 8};
    iss_en = 1; iss_addr = 5'd3; tick();
    iss_addr = 5'd4; tick();
    iss_addr = 5'd6; tick();
    idle();
    set_ra(0, 5'd3);
    #1;
    checks++; if (busy_cnt !== 6'd3) begin errors++; $display("FAIL fl_pre_cnt got %0d want 3", busy_cnt); end
    checks++; if (rhaz[0] !== 1'b1) begin errors++; $display("FAIL fl_pre_rhaz got %b want 1", rhaz[0]); end
    flush = 1; iss_en = 1; iss_addr = 5'd8;
    tick();
    idle();
    #1;
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL fl_cnt got %0d want 0", busy_cnt); end
    for (int k = 0; k < 4; k++) begin
      set_ra(0, AW'(addrs[k]));
      #1;
      checks++;
      if (rhaz[0] !== 1'b0) begin errors++; $display("FAIL fl_rhaz_r%0d got %b want 0", addrs[k], rhaz[0]); end
    end
    set_ra(0, 5'd7); set_ra(1, 5'd5);
    #1;
    checks++; if (rdp(0) !== 32'h22222222) begin errors++; $display("FAIL fl_keep_r7 got %h want 22222222", rdp(0)); end
    checks++; if (rdp(1) !== 32'hDEADBEEF) begin errors++; $display("FAIL fl_keep_r5 got %h want deadbeef", rdp(1)); end
    $display("test_flush done");
  endtask

  task automatic test_back_to_back();
    we0 = 1; wa0 = 5'd20; wd0 = 32'hAAAA0014;
    we1 = 1; wa1 = 5'd21; wd1 = 32'hBBBB0015;
    iss_en = 1; iss_addr = 5'd22;
    tick();
    idle();
    we0 = 1; wa0 = 5'd22; wd0 = 32'hCCCC0016;
    iss_en = 1; iss_addr = 5'd20;
    set_ra(0, 5'd20); set_ra(1, 5'd22);
    #1;
    checks++; if (rdp(0) !== 32'hAAAA0014) begin errors++; $display("FAIL b2b_r20 got %h want aaaa0014", rdp(0)); end
    checks++; if (rdp(1) !== 32'hCCCC0016) begin errors++; $display("FAIL b2b_r22_fwd got %h want cccc0016", rdp(1)); end
    checks++; if (rhaz !== 2'b00) begin errors++; $display("FAIL b2b_rhaz_a got %b want 00", rhaz); end
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL b2b_cnt_a got %0d want 1", busy_cnt); end
    tick();
    idle();
    #1;
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL b2b_cnt_b got %0d want 1", busy_cnt); end
    checks++; if (rhaz !== 2'b01) begin errors++; $display("FAIL b2b_rhaz_b got %b want 01", rhaz); end
    checks++; if (rdp(1) !== 32'hCCCC0016) begin errors++; $display("FAIL b2b_r22 got %h want cccc0016", rdp(1)); end
    set_ra(1, 5'd21);
    #1;
    checks++; if (rdp(1) !== 32'hBBBB0015) begin errors++; $display("FAIL b2b_r21 got %h want bbbb0015", rdp(1)); end
    flush = 1;
    tick();
    idle();
    $display("test_back_to_back done");
  endtask

  initial begin
    reset = 1'b0;
    idle();
    ra = '0;
    test_reset();
    test_dual_write();
    test_reg0();
    test_scoreboard();
    test_collision();
    test_flush();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
